// File: rtl/data_writer_if.sv
// Byte-stream handshake between a source and the data writer.
// The master drives valid/data; the slave answers with ready.
interface data_writer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/data_writer.sv
// Loadable DEPTH x WIDTH store: fills entries in order from a valid/ready stream,
// with a combinational index->byte read path.
//   state  | meaning
//   S_FILL | accepting bytes, wptr is the next entry to write
//   S_FULL | all entries written, source held off until clear/reset
module data_writer #(
  parameter int DEPTH = 11,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  data_writer_if.slave     s_in,
  input  logic             i_clear,
  input  logic [AW-1:0]    i_data_index,
  output logic [WIDTH-1:0] o_data_out,
  output logic [AW-1:0]    o_count,
  output logic             o_full,
  output logic             o_done
);

  typedef enum logic {S_FILL, S_FULL} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DEPTH_AW = AW'(DEPTH);

  state_t           r_state;
  logic [AW-1:0]    r_wptr;
  logic             r_done;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_ready;
  logic             w_xfer;

  // Ready drops combinationally with rst_n so nothing is offered during reset.
  assign w_ready       = i_rst_n && (r_state == S_FILL);
  assign w_xfer        = s_in.in_valid && w_ready;
  assign s_in.in_ready = w_ready;
  assign o_count       = r_wptr;
  assign o_full        = (r_state == S_FULL);
  assign o_done        = r_done;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_state <= S_FILL;
      r_wptr  <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_xfer) begin
        r_mem[r_wptr] <= s_in.in_data;
        r_wptr        <= r_wptr + 1'b1;
        if (r_wptr == LAST_IDX) begin
          r_state <= S_FULL;
          r_done  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_data_out = '0;
    if (i_data_index < DEPTH_AW) o_data_out = r_mem[i_data_index];
  end

endmodule

// File: tb/tb_data_writer.sv
// Directed bench for data_writer: fill, gaps, overflow, clear race, reset and
// read-during-write, all against hand-computed expectations.
module tb_data_writer;
  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [3:0] data_index;
  logic [7:0] data_out;
  logic [3:0] count;
  logic       full;
  logic       done;
  int         checks;
  int         failures;

  data_writer_if #(.WIDTH(8)) u_if ();

  data_writer #(.DEPTH(11), .WIDTH(8), .AW(4)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .s_in         (u_if.slave),
    .i_clear      (clear),
    .i_data_index (data_index),
    .o_data_out   (data_out),
    .o_count      (count),
    .o_full       (full),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d);
    u_if.in_valid = 1'b1;
    u_if.in_data  = d;
    tick();
    u_if.in_valid = 1'b0;
    u_if.in_data  = 8'h00;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic rd(input string tag, input int idx, input logic [7:0] exp);
    data_index = 4'(idx);
    #1;
    chk(tag, {24'h0, data_out}, {24'h0, exp});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    data_index = '0;
    u_if.in_valid = 1'b0;
    u_if.in_data  = 8'h00;

    // T1 reset
    tick();
    tick();
    chk("ready_in_reset", {31'h0, u_if.in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t1_ready", {31'h0, u_if.in_ready}, 32'd1);
    chk("t1_count", {28'h0, count}, 32'd0);
    chk("t1_full", {31'h0, full}, 32'd0);
    chk("t1_done", {31'h0, done}, 32'd0);
    for (int i = 0; i < 16; i++) rd("t1_data", i, 8'h00);

    // T2 back-to-back fill 0xA0..0xAA
    for (int i = 0; i < 11; i++) begin
      u_if.in_valid = 1'b1;
      u_if.in_data  = 8'hA0 + 8'(i);
      tick();
      if (i == 9) chk("t2_done_early", {31'h0, done}, 32'd0);
    end
    u_if.in_valid = 1'b0;
    chk("t2_done", {31'h0, done}, 32'd1);
    chk("t2_count", {28'h0, count}, 32'd11);
    chk("t2_full", {31'h0, full}, 32'd1);
    chk("t2_ready", {31'h0, u_if.in_ready}, 32'd0);
    tick();
    chk("t2_done_pulse", {31'h0, done}, 32'd0);
    rd("t2_rd5", 5, 8'hA5);
    rd("t2_rd10", 10, 8'hAA);
    rd("t2_rd11", 11, 8'h00);

    // T3 gaps then overflow attempt
    do_clear();
    chk("t3_cleared", {28'h0, count}, 32'd0);
    for (int i = 0; i < 22; i++) begin
      u_if.in_valid = (i % 2 == 0);
      u_if.in_data  = (i % 2 == 0) ? 8'h10 + 8'(i / 2) : 8'hEE;
      tick();
    end
    u_if.in_valid = 1'b0;
    chk("t3_count", {28'h0, count}, 32'd11);
    beat(8'hFF);
    chk("t3_count_ovf", {28'h0, count}, 32'd11);
    chk("t3_full", {31'h0, full}, 32'd1);
    for (int i = 0; i < 11; i++) rd("t3_data", i, 8'h10 + 8'(i));

    // T4 clear racing a beat at count=4
    do_clear();
    for (int i = 0; i < 4; i++) beat(8'h30 + 8'(i));
    chk("t4_count4", {28'h0, count}, 32'd4);
    clear = 1'b1;
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'h55;
    #1;
    chk("t4_ready_clear", {31'h0, u_if.in_ready}, 32'd1);
    tick();
    clear = 1'b0;
    u_if.in_valid = 1'b0;
    chk("t4_count", {28'h0, count}, 32'd0);
    for (int i = 0; i < 11; i++) rd("t4_data", i, 8'h00);
    beat(8'h66);
    chk("t4_count1", {28'h0, count}, 32'd1);
    rd("t4_rd0", 0, 8'h66);

    // T6 read-during-write at entry 3
    beat(8'h67);
    beat(8'h68);
    data_index = 4'd3;
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'h77;
    #1;
    chk("t6_old", {24'h0, data_out}, 32'h00);
    tick();
    u_if.in_valid = 1'b0;
    chk("t6_new", {24'h0, data_out}, 32'h77);

    // Clear on the same edge as the last transfer
    do_clear();
    for (int i = 0; i < 10; i++) beat(8'hC0 + 8'(i));
    clear = 1'b1;
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'hCA;
    tick();
    clear = 1'b0;
    u_if.in_valid = 1'b0;
    chk("race_done", {31'h0, done}, 32'd0);
    chk("race_count", {28'h0, count}, 32'd0);
    chk("race_full", {31'h0, full}, 32'd0);
    rd("race_rd9", 9, 8'h00);

    // T5 reset mid-fill then refill
    for (int i = 0; i < 6; i++) beat(8'h40 + 8'(i));
    chk("t5_count6", {28'h0, count}, 32'd6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_count", {28'h0, count}, 32'd0);
    for (int i = 0; i < 11; i++) rd("t5_data", i, 8'h00);
    for (int i = 0; i < 11; i++) beat(8'h01 + 8'(i));
    rd("t5_rd0", 0, 8'h01);
    rd("t5_rd10", 10, 8'h0B);
    chk("t5_full", {31'h0, full}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
